// File: rtl/leading_one_scan.sv
// leading_one_scan: multi-cycle leading/trailing one finder, scanning CHUNK bits per cycle
// with early termination behind valid/ready handshakes.
module leading_one_scan #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   localparam int NCHUNK = (WIDTH + CHUNK - 1) / CHUNK,
   localparam int IDX_W = $clog2(WIDTH) + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_mode,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] out_index,
   output logic             out_zero
);
   localparam int PW = NCHUNK * CHUNK;
   localparam int PTR_W = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

   typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

   state_t state, next;
   logic [PW-1:0] word;
   logic mode;
   logic [PTR_W-1:0] ptr, sel;
   logic [CHUNK-1:0] slice;
   logic [IDX_W-1:0] pos_hi, pos_lo, idx;
   logic hit, last;

   // leading mode walks slices from the top, trailing mode from the bottom
   assign sel = mode ? ptr : PTR_W'(NCHUNK - 1) - ptr;
   assign slice = CHUNK'(word >> (sel * CHUNK));
   assign hit = |slice;
   assign last = ptr == PTR_W'(NCHUNK - 1);
   assign idx = IDX_W'(sel * CHUNK) + (mode ? pos_lo : pos_hi);
   assign in_ready = state == IDLE;
   assign out_valid = state == DONE;

   always_comb begin
      pos_hi = '0;
      pos_lo = '0;
      for (int i = 0; i < CHUNK; i++)
         if (slice[i]) pos_hi = IDX_W'(i);
      for (int i = CHUNK - 1; i >= 0; i--)
         if (slice[i]) pos_lo = IDX_W'(i);
   end

   always_comb begin
      next = state;
      next = state == IDLE ? (in_valid ? SCAN : IDLE)
           : state == SCAN ? (hit || last ? DONE : SCAN)
           : (out_ready ? IDLE : DONE);
   end

   always_ff @(posedge clk or posedge rst)
      if (rst) state <= IDLE;
      else state <= next;

   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         word <= '0;
         mode <= 1'b0;
         ptr <= '0;
         out_index <= '0;
         out_zero <= 1'b0;
      end else if (state == IDLE && in_valid) begin
         word <= PW'(in_data);
         mode <= in_mode;
         ptr <= '0;
      end else if (state == SCAN) begin
         if (hit) begin
            out_index <= idx;
            out_zero <= 1'b0;
         end else if (last) begin
            out_index <= '1;
            out_zero <= 1'b1;
         end else
            ptr <= ptr + 1'b1;
      end
endmodule

// File: tb/tb_leading_one_scan.sv
// tb_leading_one_scan: table-driven, random and exhaustive checks of the leading-one scanner
// against a bit-level reference model.
module tb_leading_one_scan;
   logic clk = 1'b0, rst = 1'b1;
   always #5 clk = ~clk;

   int total = 0, bad = 0;

   logic a_in_valid = 0, a_in_mode = 0, a_out_ready = 0;
   logic [31:0] a_in_data = '0;
   logic a_in_ready, a_out_valid, a_out_zero;
   logic [5:0] a_out_index;

   logic b_in_valid = 0, b_out_ready = 0;
   logic [8:0] b_in_data = '0;
   logic b_in_ready, b_out_valid, b_out_zero;
   logic [4:0] b_out_index;

   leading_one_scan #(.WIDTH(32), .CHUNK(8)) dut_a (
      .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_data(a_in_data), .in_mode(a_in_mode), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_index(a_out_index), .out_zero(a_out_zero));

   leading_one_scan #(.WIDTH(9), .CHUNK(4)) dut_b (
      .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .in_mode(1'b0), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_index(b_out_index), .out_zero(b_out_zero));

   typedef struct {
      logic [31:0] data;
      logic        mode;
      int          idx;
      logic        zero;
      int          lat;
   } vec_t;

   task automatic chk(input string nm, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // bit index of the MSB (mode 0) or LSB (mode 1) set among the low w bits, -1 if none
   function automatic int ref_idx(input logic [31:0] d, input int w, input logic m);
      int r = -1;
      for (int i = 0; i < w; i++)
         if (d[i]) begin
            if (!m) r = i;
            else if (r < 0) r = i;
         end
      return r;
   endfunction

   // cycles from accept to out_valid: one per slice visited up to and including the hit
   function automatic int ref_lat(input int idx, input int w, input int c, input logic m);
      int n = (w + c - 1) / c;
      if (idx < 0) return n;
      return m ? idx / c + 1 : n - idx / c;
   endfunction

   task automatic req_a(input logic [31:0] d, input logic m, output int idx, output logic z,
                        output int lat);
      int n = 0;
      while (!a_in_ready && n < 20) begin @(negedge clk); n++; end
      a_in_valid = 1; a_in_data = d; a_in_mode = m;
      @(negedge clk);
      a_in_valid = 0;
      lat = 0;
      while (!a_out_valid && lat < 20) begin @(negedge clk); lat++; end
      idx = int'(a_out_index); z = a_out_zero;
      a_out_ready = 1;
      @(negedge clk);
      a_out_ready = 0;
   endtask

   task automatic req_b(input logic [8:0] d, output int idx, output logic z, output int lat);
      int n = 0;
      while (!b_in_ready && n < 20) begin @(negedge clk); n++; end
      b_in_valid = 1; b_in_data = d;
      @(negedge clk);
      b_in_valid = 0;
      lat = 0;
      while (!b_out_valid && lat < 20) begin @(negedge clk); lat++; end
      idx = int'(b_out_index); z = b_out_zero;
      b_out_ready = 1;
      @(negedge clk);
      b_out_ready = 0;
   endtask

   task automatic check_a(input string nm, input logic [31:0] d, input logic m);
      int idx, lat, r;
      logic z;
      req_a(d, m, idx, z, lat);
      r = ref_idx(d, 32, m);
      chk({nm, " index"}, idx, r < 0 ? 63 : r);
      chk({nm, " zero"}, z, r < 0);
      chk({nm, " latency"}, lat, ref_lat(r, 32, 8, m));
   endtask

   initial begin
      vec_t tbl[9];
      int idx, lat, r;
      logic z, seen;
      tbl[0] = '{32'h8000_0000, 0, 31, 0, 1};
      tbl[1] = '{32'h0000_0001, 0, 0, 0, 4};
      tbl[2] = '{32'h0000_0001, 1, 0, 0, 1};
      tbl[3] = '{32'h0000_0000, 0, 63, 1, 4};
      tbl[4] = '{32'h0000_0000, 1, 63, 1, 4};
      tbl[5] = '{32'h0001_0100, 0, 16, 0, 2};
      tbl[6] = '{32'h0001_0100, 1, 8, 0, 2};
      tbl[7] = '{32'hFFFF_FFFF, 0, 31, 0, 1};
      tbl[8] = '{32'h8000_0000, 1, 31, 0, 4};

      #2;
      chk("reset in_ready", a_in_ready, 1);
      chk("reset out_valid", a_out_valid, 0);
      chk("reset out_index", a_out_index, 0);
      chk("reset out_zero", a_out_zero, 0);
      @(negedge clk);
      rst = 0;
      @(negedge clk);

      for (int i = 0; i < 9; i++) begin
         req_a(tbl[i].data, tbl[i].mode, idx, z, lat);
         chk($sformatf("vec%0d index", i), idx, tbl[i].idx);
         chk($sformatf("vec%0d zero", i), z, tbl[i].zero);
         chk($sformatf("vec%0d latency", i), lat, tbl[i].lat);
      end

      for (int i = 0; i < 150; i++) begin
         logic [31:0] d;
         d = $urandom;
         if (i % 3 == 1) d = d & $urandom & $urandom & $urandom;
         if (i % 3 == 2) d = 32'h1 << $urandom_range(31, 0);
         check_a($sformatf("rnd%0d", i), d, 1'($urandom));
      end

      // back-pressure: result held while out_ready is low, in_valid pulses ignored
      a_in_valid = 1; a_in_data = 32'h0000_0100; a_in_mode = 0;
      @(negedge clk);
      a_in_valid = 0;
      lat = 0;
      while (!a_out_valid && lat < 20) begin @(negedge clk); lat++; end
      chk("bp latency", lat, 3);
      for (int i = 0; i < 5; i++) begin
         a_in_valid = 1; a_in_data = $urandom | 32'h8000_0000; a_in_mode = 1'($urandom);
         @(negedge clk);
         chk("bp hold out_valid", a_out_valid, 1);
         chk("bp hold out_index", a_out_index, 8);
         chk("bp hold out_zero", a_out_zero, 0);
         chk("bp hold in_ready", a_in_ready, 0);
      end
      a_in_valid = 0; a_out_ready = 1;
      @(negedge clk);
      a_out_ready = 0;
      chk("bp release out_valid", a_out_valid, 0);
      chk("bp release in_ready", a_in_ready, 1);
      chk("bp release index kept", a_out_index, 8);
      check_a("bp next", 32'h0000_0004, 1);

      // asynchronous reset during the scan discards the pending result
      a_in_valid = 1; a_in_data = 32'h1; a_in_mode = 0;
      @(negedge clk);
      a_in_valid = 0;
      @(negedge clk);
      #2 rst = 1;
      #1;
      chk("midscan rst out_valid", a_out_valid, 0);
      chk("midscan rst in_ready", a_in_ready, 1);
      chk("midscan rst out_index", a_out_index, 0);
      @(negedge clk);
      rst = 0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         seen |= a_out_valid;
      end
      chk("post rst no result", seen, 0);
      chk("post rst in_ready", a_in_ready, 1);
      check_a("post rst req", 32'h0040_0000, 0);

      for (int v = 0; v < 512; v++) begin
         req_b(9'(v), idx, z, lat);
         r = ref_idx(32'(v), 9, 0);
         chk($sformatf("w9 %0d index", v), idx, r < 0 ? 31 : r);
         chk($sformatf("w9 %0d zero", v), z, r < 0);
         chk($sformatf("w9 %0d latency", v), lat, ref_lat(r, 9, 4, 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
